// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the iterative AES-128 decryption sequencer.
package aes_dec_pkg;
  localparam int NR  = 10;
  localparam int KIW = 4;

  typedef logic [15:0][7:0] block_t;
  typedef logic [KIW-1:0]   kidx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam kidx_t KI_LAST = kidx_t'(NR);
endpackage

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption sequencer: drives an external inverse-round
// datapath NR times, then applies the last AddRoundKey into the output register.
module aes_dec_ctrl
  import aes_dec_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  block_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output block_t out_data,
  input  logic   abort,
  output logic   busy,
  output kidx_t  rk_idx,
  input  block_t rk_data,
  output block_t rd_data,
  output block_t rd_key,
  output logic   rd_skip_mix,
  input  block_t rd_out
);

  state_e r_state, w_next;
  block_t r_st, r_out;
  kidx_t  r_rnd;
  logic   w_abort;

  // abort only matters once a block is in flight; in IDLE it must not block an accept
  assign w_abort = abort && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ROUND;
      S_ROUND: if (r_rnd == kidx_t'(1)) w_next = S_FINAL;
      S_FINAL: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    out_valid   = (r_state == S_DONE);
    rk_idx      = KI_LAST;
    rd_skip_mix = 1'b0;
    case (r_state)
      S_ROUND: begin
        rk_idx      = r_rnd;
        rd_skip_mix = (r_rnd == KI_LAST);
      end
      S_FINAL: rk_idx = '0;
      default: rk_idx = KI_LAST;
    endcase
  end

  // Block state, round counter and plaintext register; all frozen by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= '0;
      r_rnd <= '0;
      r_out <= '0;
    end else if (!w_abort) begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_st  <= in_data;
          r_rnd <= KI_LAST;
        end
        S_ROUND: begin
          r_st <= rd_out;
          if (r_rnd != kidx_t'(1)) r_rnd <= r_rnd - kidx_t'(1);
        end
        S_FINAL: r_out <= r_st ^ rk_data;
        default: ;
      endcase
    end
  end

  assign rd_data  = r_st;
  assign rd_key   = rk_data;
  assign out_data = r_out;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: models key store and inverse-round datapath, checks
// plaintexts against an independent AES-128 forward cipher.
module tb_aes_dec_ctrl;
  import aes_dec_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n, in_valid, in_ready, out_valid, out_ready, abort, busy, rd_skip_mix;
  block_t in_data, out_data, rk_data, rd_data, rd_key, rd_out;
  kidx_t  rk_idx;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0] sb [256];
  logic [7:0] isb[256];
  block_t rks[11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .abort(abort), .busy(busy), .rk_idx(rk_idx),
    .rk_data(rk_data), .rd_data(rd_data), .rd_key(rd_key),
    .rd_skip_mix(rd_skip_mix), .rd_out(rd_out)
  );

  // ---------------- AES reference primitives (AES byte i is block[15-i]) ----
  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic block_t sub(block_t s, bit inv);
    for (int i = 0; i < 16; i++) s[i] = inv ? isb[s[i]] : sb[s[i]];
    return s;
  endfunction

  function automatic block_t shift(block_t s, bit inv);
    block_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[15-(r+4*c)] = inv ? s[15-(r+4*((c-r+4)%4))] : s[15-(r+4*((c+r)%4))];
    return o;
  endfunction

  function automatic block_t mix(block_t s, bit inv);
    block_t o;
    logic [7:0] cf[4];
    logic [7:0] a[4];
    logic [7:0] v;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[15-(4*c+r)];
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v ^= gm(a[(r+k)%4], cf[k]);
        o[15-(4*c+r)] = v;
      end
    end
    return o;
  endfunction

  function automatic void expand(logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic block_t encrypt(block_t pt);
    block_t s = pt ^ rks[0];
    for (int r = 1; r < 10; r++) s = mix(shift(sub(s, 1'b0), 1'b0), 1'b0) ^ rks[r];
    return shift(sub(s, 1'b0), 1'b0) ^ rks[10];
  endfunction

  function automatic block_t inv_round(block_t d, block_t k, logic skip);
    block_t x = d ^ k;
    if (!skip) x = mix(x, 1'b1);
    return sub(shift(x, 1'b1), 1'b1);
  endfunction

  function automatic block_t rblk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Key store and datapath neighbours of the controller
  always_comb rk_data = (rk_idx <= kidx_t'(NR)) ? rks[rk_idx] : '0;
  assign rd_out = inv_round(rd_data, rd_key, rd_skip_mix);

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic send(input block_t ct, output bit ok);
    int n = 0;
    in_data = ct; in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    vectors++; if (rk_idx !== kidx_t'(NR)) begin miscompares++; $display("FAIL reset_rk_idx: got %0d exp %0d", rk_idx, NR); end
    vectors++; if (rd_skip_mix !== 1'b0) begin miscompares++; $display("FAIL reset_skip_mix: got %b exp 0", rd_skip_mix); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    block_t ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    block_t pt = 128'h00112233445566778899aabbccddeeff;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    in_data = ct; in_valid = 1'b1;
    vectors++; if (rk_idx !== kidx_t'(NR)) begin miscompares++; $display("FAIL fips_accept_rk_idx: got %0d exp %0d", rk_idx, NR); end
    @(posedge clk); #1; in_valid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      vectors++; if (rk_idx !== kidx_t'(NR-k)) begin miscompares++; $display("FAIL fips_round_rk_idx: got %0d exp %0d", rk_idx, NR-k); end
      vectors++; if (rd_skip_mix !== (k == 0)) begin miscompares++; $display("FAIL fips_skip_mix: got %b exp %b at round %0d", rd_skip_mix, (k == 0), k); end
      @(posedge clk); #1;
    end
    vectors++; if (rk_idx !== kidx_t'(0)) begin miscompares++; $display("FAIL fips_final_rk_idx: got %0d exp 0", rk_idx); end
    vectors++; if ({out_valid, rd_skip_mix} !== 2'b00) begin miscompares++; $display("FAIL fips_final_flags: got %b exp 00", {out_valid, rd_skip_mix}); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fips_latency: out_valid got %b exp 1 at 11 edges", out_valid); end
    vectors++; if (out_data !== pt) begin miscompares++; $display("FAIL fips_plaintext: got %h exp %h", out_data, pt); end
    vectors++; if (rk_idx !== kidx_t'(NR)) begin miscompares++; $display("FAIL fips_done_rk_idx: got %0d exp %0d", rk_idx, NR); end
    release_out();
    vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL fips_after_handshake: got %b exp 10", {in_ready, out_valid}); end
  endtask

  task automatic test_random();
    block_t pt, ct;
    bit ok; int n;
    expand(rblk());
    for (int b = 0; b < 4; b++) begin
      pt = rblk(); ct = encrypt(pt);
      send(ct, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand_accept_timeout: got 0 exp 1"); end
      wait_valid(n, ok);
      vectors++; if (n !== 11) begin miscompares++; $display("FAIL rand_latency: got %0d exp 11", n); end
      vectors++; if (out_data !== pt) begin miscompares++; $display("FAIL rand_plaintext: got %h exp %h", out_data, pt); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    block_t pt1 = rblk(), pt2 = rblk();
    block_t ct1, ct2;
    bit ok; int n;
    ct1 = encrypt(pt1); ct2 = encrypt(pt2);
    send(ct1, ok);
    wait_valid(n, ok);
    in_data = ct2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++; if ({out_valid, in_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_flags: got %b exp 10 cycle %0d", {out_valid, in_ready}, k); end
      vectors++; if (out_data !== pt1) begin miscompares++; $display("FAIL bp_hold_data: got %h exp %h", out_data, pt1); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    vectors++; if ({in_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL bp_idle_after_release: got %b exp 10", {in_ready, busy}); end
    @(posedge clk); #1; in_valid = 1'b0;
    vectors++; if ({busy, rd_data} !== {1'b1, ct2}) begin miscompares++; $display("FAIL bp_second_accept: got %b/%h exp 1/%h", busy, rd_data, ct2); end
    wait_valid(n, ok);
    vectors++; if (out_data !== pt2 || !ok) begin miscompares++; $display("FAIL bp_second_plaintext: got %h exp %h", out_data, pt2); end
    release_out();
  endtask

  task automatic test_back_to_back();
    block_t pt[3];
    block_t ct[3];
    int acc[3];
    int n; bit ok;
    expand(rblk());
    for (int i = 0; i < 3; i++) begin pt[i] = rblk(); ct[i] = encrypt(pt[i]); end
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
      acc[i] = cyc; in_data = ct[i];
      @(posedge clk); #1;
      if (i == 2) in_valid = 1'b0;
      wait_valid(n, ok);
      vectors++; if (out_data !== pt[i] || !ok) begin miscompares++; $display("FAIL b2b_plaintext%0d: got %h exp %h", i, out_data, pt[i]); end
    end
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (acc[i+1] - acc[i] !== 13) begin miscompares++; $display("FAIL b2b_period: got %0d exp 13", acc[i+1] - acc[i]); end
    end
  endtask

  task automatic test_abort();
    block_t pt = rblk(), pt2 = rblk(), held;
    bit ok, rose = 1'b0; int n;
    send(encrypt(pt), ok);
    repeat (5) begin @(posedge clk); #1; end
    vectors++; if (rk_idx !== kidx_t'(5)) begin miscompares++; $display("FAIL abort_at_rnd5: got %0d exp 5", rk_idx); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    vectors++; if ({in_ready, busy, out_valid} !== 3'b100) begin miscompares++; $display("FAIL abort_idle: got %b exp 100", {in_ready, busy, out_valid}); end
    repeat (15) begin @(posedge clk); #1; rose |= out_valid; end
    vectors++; if (rose !== 1'b0) begin miscompares++; $display("FAIL abort_no_valid: got %b exp 0", rose); end
    send(encrypt(pt2), ok);
    wait_valid(n, ok);
    vectors++; if (out_data !== pt2 || n !== 11) begin miscompares++; $display("FAIL abort_next_block: got %h/%0d exp %h/11", out_data, n, pt2); end
    // abort while holding the result: valid drops, register keeps its value
    held = out_data;
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    vectors++; if ({out_valid, in_ready} !== 2'b01 || out_data !== held) begin miscompares++; $display("FAIL abort_in_done: got %b/%h exp 01/%h", {out_valid, in_ready}, out_data, held); end
    // abort in IDLE must not suppress the same-cycle accept
    abort = 1'b1; send(encrypt(pt), ok); abort = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_idle_accept: got %b exp 1", busy); end
    wait_valid(n, ok);
    vectors++; if (out_data !== pt || !ok) begin miscompares++; $display("FAIL abort_idle_plaintext: got %h exp %h", out_data, pt); end
    release_out();
  endtask

  task automatic test_reset_mid();
    block_t pt = rblk();
    bit ok; int n;
    send(encrypt(rblk()), ok);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    vectors++; if ({out_valid, busy, in_ready} !== 3'b001) begin miscompares++; $display("FAIL rstmid_flags: got %b exp 001", {out_valid, busy, in_ready}); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rstmid_out_data: got %h exp 0", out_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b exp 1", in_ready); end
    send(encrypt(pt), ok);
    wait_valid(n, ok);
    vectors++; if (out_data !== pt || n !== 11) begin miscompares++; $display("FAIL rstmid_resume: got %h/%0d exp %h/11", out_data, n, pt); end
    release_out();
  endtask

  initial begin
    logic [7:0] inv, s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; in_data = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gm(inv, x[7:0]);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s; isb[s] = x[7:0];
    end
    for (int r = 0; r < 11; r++) rks[r] = '0;
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
